// File: rtl/alarm_timer.sv
// Programmable down-counting alarm timer with a prescaled tick, auto-reload
// and a level interrupt, accessed through a small four-register CPU port.
module alarm_timer #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] load_q, load_d;
  logic [15:0] count_q, count_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic        irq_q, irq_d;
  logic [15:0] rdata_q, rdata_d;

  logic tick;
  logic load_wr, ctrl_wr, stat_wr;

  assign tick    = (state_q == RUN) && (pcnt_q == PCNT_MAX);
  assign load_wr = wr_en && (addr == 2'd0);
  assign ctrl_wr = wr_en && (addr == 2'd1);
  assign stat_wr = wr_en && (addr == 2'd2);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    exp_d   = exp_q;
    irq_d   = exp_q & ie_q;
    rdata_d = rdata_q;

    // Reads see the register contents from before any same-cycle write.
    if (rd_en) begin
      case (addr)
        2'd0:    rdata_d = load_q;
        2'd1:    rdata_d = {13'd0, ie_q, auto_q, en_q};
        2'd2:    rdata_d = {15'd0, exp_q};
        default: rdata_d = count_q;
      endcase
    end

    if (state_q == RUN) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    end

    // Clear first so that a simultaneous expiry below overrides it.
    if (stat_wr && wdata[0]) begin
      exp_d = 1'b0;
    end

    if (load_wr) begin
      load_d  = wdata;
      count_d = wdata;
      pcnt_d  = 16'd0;
      state_d = (en_q && (wdata != 16'd0)) ? RUN : IDLE;
    end else if (tick) begin
      if (count_q > 16'd1) begin
        count_d = count_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (auto_q) begin
          count_d = load_q;
        end else begin
          count_d = 16'd0;
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
    end

    if (ctrl_wr) begin
      en_d   = wdata[0];
      auto_d = wdata[1];
      ie_d   = wdata[2];
      if (!wdata[0]) begin
        state_d = IDLE;
      end else if (!en_q && (count_q != 16'd0)) begin
        state_d = RUN;
        pcnt_d  = 16'd0;
      end
    end

    if (state_d == IDLE) begin
      pcnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= 16'd0;
      load_q  <= 16'd0;
      count_q <= 16'd0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
